// File: rtl/dbg_apb_pkg.sv
// rtl/dbg_apb_pkg.sv - shared types and helpers for the debug-port to APB bridge
package dbg_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } bridge_state_t;

    // Slave-index width; never narrower than one bit even for a single slave.
    function automatic int sel_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dbg_apb_bridge_if.sv
// rtl/dbg_apb_bridge_if.sv - request/response handshake plus shared APB bus bundle
interface dbg_apb_bridge_if #(
    parameter int NR_SLAVES  = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    import dbg_apb_pkg::*;

    localparam int SEL_W  = sel_w(NR_SLAVES);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic                            req_valid;
    logic                            req_ready;
    logic [SEL_W-1:0]                req_slave;
    logic                            req_wr_rd;
    logic [ADDR_WIDTH-1:0]           req_addr;
    logic [DATA_WIDTH-1:0]           req_wdata;
    logic [STRB_W-1:0]               req_wstrobe;
    logic                            rsp_valid;
    logic                            rsp_ready;
    logic [DATA_WIDTH-1:0]           rsp_rdata;
    logic                            rsp_err;
    logic [ADDR_WIDTH-1:0]           paddr;
    logic                            pwrite;
    logic [DATA_WIDTH-1:0]           pwdata;
    logic [STRB_W-1:0]               pstrb;
    logic [NR_SLAVES-1:0]            psel;
    logic                            penable;
    logic [NR_SLAVES-1:0]            pready;
    logic [NR_SLAVES-1:0]            pslverr;
    logic [NR_SLAVES*DATA_WIDTH-1:0] prdata;

    // Bridge side.
    modport slave (
        input  req_valid, req_slave, req_wr_rd, req_addr, req_wdata, req_wstrobe,
        input  rsp_ready, pready, pslverr, prdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output paddr, pwrite, pwdata, pstrb, psel, penable
    );

    // Requester and APB slaves side.
    modport master (
        output req_valid, req_slave, req_wr_rd, req_addr, req_wdata, req_wstrobe,
        output rsp_ready, pready, pslverr, prdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  paddr, pwrite, pwdata, pstrb, psel, penable
    );

endinterface

// File: rtl/dbg_apb_timeout.sv
// rtl/dbg_apb_timeout.sv - ACCESS-phase wait counter; expired flags the cycle whose wait reaches TIMEOUT
module dbg_apb_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int unsigned CW   = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    logic [CW-1:0] r_cnt;
    logic          w_active;

    assign w_active  = i_en && (TIMEOUT != 0);
    assign o_expired = w_active && (r_cnt == CW'(LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (w_active && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dbg_apb_bridge.sv
// rtl/dbg_apb_bridge.sv - single-outstanding debug-port request to multi-slave APB master bridge
module dbg_apb_bridge
    import dbg_apb_pkg::*;
#(
    parameter int          NR_SLAVES  = 4,
    parameter int          ADDR_WIDTH = 5,
    parameter int          DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic              clk,
    input logic              rst_n,
    dbg_apb_bridge_if.slave  bus
);
    localparam int SEL_W  = sel_w(NR_SLAVES);
    localparam int STRB_W = DATA_WIDTH / 8;

    bridge_state_t         r_state;
    logic [SEL_W-1:0]      r_idx;
    logic [NR_SLAVES-1:0]  r_psel;
    logic                  r_penable;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [STRB_W-1:0]     r_pstrb;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    logic                  w_req_ok;
    logic [NR_SLAVES-1:0]  w_onehot;
    logic                  w_pready;
    logic                  w_pslverr;
    logic [DATA_WIDTH-1:0] w_prdata;
    logic                  w_accept;
    logic                  w_expired;

    assign w_req_ok  = int'(bus.req_slave) < NR_SLAVES;
    assign w_accept  = (r_state == ST_IDLE) && bus.req_valid && w_req_ok;
    // Only the latched slave's response lines are ever looked at.
    assign w_pready  = bus.pready[r_idx];
    assign w_pslverr = bus.pslverr[r_idx];
    assign w_prdata  = bus.prdata[int'(r_idx) * DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NR_SLAVES; i++) begin
            w_onehot[i] = (int'(bus.req_slave) == i);
        end
    end

    dbg_apb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_accept),
        .i_en      ((r_state == ST_ACCESS) && !w_pready),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        if (w_req_ok) begin
                            r_idx    <= bus.req_slave;
                            r_psel   <= w_onehot;
                            r_paddr  <= bus.req_addr;
                            r_pwrite <= bus.req_wr_rd;
                            r_pwdata <= bus.req_wdata;
                            r_pstrb  <= bus.req_wr_rd ? bus.req_wstrobe : '0;
                            r_state  <= ST_SETUP;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A ready slave wins over a timeout hitting in the same cycle.
                    if (w_pready || w_expired) begin
                        r_psel      <= '0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_pready ? w_pslverr : 1'b1;
                        r_rsp_rdata <= (w_pready && !r_pwrite && !w_pslverr) ? w_prdata : '0;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.paddr     = r_paddr;
    assign bus.pwrite    = r_pwrite;
    assign bus.pwdata    = r_pwdata;
    assign bus.pstrb     = r_pstrb;
    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;

endmodule

// File: tb/tb_dbg_apb_bridge.sv
// tb/tb_dbg_apb_bridge.sv - directed scoreboard bench for dbg_apb_bridge (4-slave/TIMEOUT=8 and 3-slave/no-timeout instances)
module tb_dbg_apb_bridge;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         which;
    logic         req_valid;
    logic [1:0]   req_slave;
    logic         req_wr_rd;
    logic [4:0]   req_addr;
    logic [31:0]  req_wdata;
    logic [3:0]   req_wstrobe;
    logic         rsp_ready;
    logic [3:0]   pready;
    logic [3:0]   pslverr;
    logic [127:0] prdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    dbg_apb_bridge_if #(.NR_SLAVES(4), .ADDR_WIDTH(5), .DATA_WIDTH(32)) ifa ();
    dbg_apb_bridge_if #(.NR_SLAVES(3), .ADDR_WIDTH(5), .DATA_WIDTH(32)) ifb ();

    dbg_apb_bridge #(.NR_SLAVES(4), .ADDR_WIDTH(5), .DATA_WIDTH(32), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    dbg_apb_bridge #(.NR_SLAVES(3), .ADDR_WIDTH(5), .DATA_WIDTH(32), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    assign ifa.req_valid   = req_valid && !which;
    assign ifb.req_valid   = req_valid && which;
    assign ifa.req_slave   = req_slave;
    assign ifb.req_slave   = req_slave;
    assign ifa.req_wr_rd   = req_wr_rd;
    assign ifb.req_wr_rd   = req_wr_rd;
    assign ifa.req_addr    = req_addr;
    assign ifb.req_addr    = req_addr;
    assign ifa.req_wdata   = req_wdata;
    assign ifb.req_wdata   = req_wdata;
    assign ifa.req_wstrobe = req_wstrobe;
    assign ifb.req_wstrobe = req_wstrobe;
    assign ifa.rsp_ready   = rsp_ready && !which;
    assign ifb.rsp_ready   = rsp_ready && which;
    assign ifa.pready      = pready;
    assign ifb.pready      = pready[2:0];
    assign ifa.pslverr     = pslverr;
    assign ifb.pslverr     = pslverr[2:0];
    assign ifa.prdata      = prdata;
    assign ifb.prdata      = prdata[95:0];

    wire        o_req_ready = which ? ifb.req_ready : ifa.req_ready;
    wire        o_rsp_valid = which ? ifb.rsp_valid : ifa.rsp_valid;
    wire        o_rsp_err   = which ? ifb.rsp_err   : ifa.rsp_err;
    wire [31:0] o_rsp_rdata = which ? ifb.rsp_rdata : ifa.rsp_rdata;
    wire [3:0]  o_psel      = which ? {1'b0, ifb.psel} : ifa.psel;
    wire        o_penable   = which ? ifb.penable   : ifa.penable;
    wire [4:0]  o_paddr     = which ? ifb.paddr     : ifa.paddr;
    wire        o_pwrite    = which ? ifb.pwrite    : ifa.pwrite;
    wire [31:0] o_pwdata    = which ? ifb.pwdata    : ifa.pwdata;
    wire [3:0]  o_pstrb     = which ? ifb.pstrb     : ifa.pstrb;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with the selected DUT idle.
    task automatic run_txn(input int slv, input bit wr, input logic [4:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb, input int waits,
                           input bit slverr, input logic [31:0] rdata, input int stall);
        int   nr;
        int   tmo;
        int   c;
        bit   bad;
        exp_t e;
        exp_t got;
        logic [3:0] oh;
        nr  = which ? 3 : 4;
        tmo = which ? 0 : 8;
        bad = (slv >= nr);
        oh  = 4'b0001 << slv;
        if (bad) begin
            e.lat = 1; e.err = 1'b1; e.rd = '0;
        end else if (tmo != 0 && waits >= tmo) begin
            e.lat = 2 + tmo; e.err = 1'b1; e.rd = '0;
        end else begin
            e.lat = 3 + waits; e.err = slverr; e.rd = (wr || slverr) ? 32'h0 : rdata;
        end
        sb.push_back(e);

        // Unselected slaves shout ready/error/garbage the whole time.
        pready  = ~oh;
        pslverr = ~oh;
        if (slverr) pslverr[slv] = 1'b1;
        for (int i = 0; i < 4; i++) prdata[i*32 +: 32] = 32'hBAD0_0000 | i;
        if (!bad) prdata[slv*32 +: 32] = rdata;

        req_slave   = slv[1:0];
        req_wr_rd   = wr;
        req_addr    = addr;
        req_wdata   = wdata;
        req_wstrobe = strb;
        req_valid   = 1'b1;
        chk("req_ready_idle", o_req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        c = 1;
        while (c <= 40 && !o_rsp_valid) begin
            chk("req_ready_busy", o_req_ready, 1'b0);
            chk("psel", o_psel, bad ? 4'b0000 : oh);
            chk("penable", o_penable, (!bad && c >= 2));
            if (!bad) begin
                chk("paddr", o_paddr, addr);
                chk("pwrite", o_pwrite, wr);
                chk("pwdata", o_pwdata, wdata);
                chk("pstrb", o_pstrb, wr ? strb : 4'b0000);
            end
            if (!bad) pready[slv] = (c >= 2) && (c - 2 >= waits);
            @(posedge clk);
            @(negedge clk);
            c++;
        end
        got = sb.pop_front();
        chk("rsp_valid_seen", o_rsp_valid, 1'b1);
        chk("latency", c, got.lat);
        chk("rsp_err", o_rsp_err, got.err);
        chk("rsp_rdata", o_rsp_rdata, got.rd);
        chk("psel_resp", o_psel, 4'b0000);
        chk("penable_resp", o_penable, 1'b0);
        if (!bad) pready[slv] = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", o_rsp_valid, 1'b1);
            chk("stall_err", o_rsp_err, got.err);
            chk("stall_rdata", o_rsp_rdata, got.rd);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        chk("req_ready_resp", o_req_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", o_rsp_valid, 1'b0);
        chk("req_ready_back", o_req_ready, 1'b1);
        chk("psel_idle", o_psel, 4'b0000);
    endtask

    initial begin
        rst_n       = 1'b0;
        which       = 1'b0;
        req_valid   = 1'b0;
        req_slave   = '0;
        req_wr_rd   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_wstrobe = '0;
        rsp_ready   = 1'b0;
        pready      = '0;
        pslverr     = '0;
        prdata      = '0;
        #2;
        chk("rst_psel", o_psel, 4'b0000);
        chk("rst_penable", o_penable, 1'b0);
        chk("rst_rsp_valid", o_rsp_valid, 1'b0);
        chk("rst_rsp_err", o_rsp_err, 1'b0);
        chk("rst_rsp_rdata", o_rsp_rdata, 32'h0);
        chk("rst_paddr", o_paddr, 5'h0);
        chk("rst_pwdata", o_pwdata, 32'h0);
        chk("rst_pstrb", o_pstrb, 4'h0);
        chk("rst_pwrite", o_pwrite, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(2, 1'b1, 5'h0A, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0, 0);
        run_txn(1, 1'b0, 5'h04, 32'h0, 4'hF, 3, 1'b0, 32'h12345678, 0);
        run_txn(3, 1'b0, 5'h1F, 32'h0, 4'h0, 0, 1'b1, 32'hCAFEF00D, 0);
        run_txn(0, 1'b0, 5'h01, 32'h0, 4'h0, 0, 1'b0, 32'hAA55AA55, 0);
        run_txn(0, 1'b0, 5'h02, 32'h0, 4'h0, 8, 1'b0, 32'h11111111, 0);
        run_txn(2, 1'b0, 5'h03, 32'h0, 4'h0, 7, 1'b0, 32'h76543210, 1);
        run_txn(1, 1'b1, 5'h15, 32'h0BADF00D, 4'b0101, 2, 1'b0, 32'h0, 0);

        // Abort a transaction mid-ACCESS with an asynchronous reset.
        pready      = '0;
        pslverr     = '0;
        req_slave   = 2'd0;
        req_wr_rd   = 1'b1;
        req_addr    = 5'h11;
        req_wdata   = 32'h55AA55AA;
        req_wstrobe = 4'hF;
        req_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_penable", o_penable, 1'b1);
        chk("pre_rst_psel", o_psel, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_psel", o_psel, 4'b0000);
        chk("arst_penable", o_penable, 1'b0);
        chk("arst_rsp_valid", o_rsp_valid, 1'b0);
        chk("arst_paddr", o_paddr, 5'h0);
        chk("arst_req_ready", o_req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(3, 1'b0, 5'h07, 32'h0, 4'h0, 1, 1'b0, 32'h89ABCDEF, 5);

        which = 1'b1;
        @(negedge clk);
        run_txn(3, 1'b0, 5'h02, 32'h0, 4'h0, 0, 1'b0, 32'h0, 2);
        run_txn(2, 1'b0, 5'h09, 32'h0, 4'h0, 20, 1'b0, 32'hFEEDC0DE, 0);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dbg_apb_bridge.md
DBG_APB_BRIDGE -- requirements
Module: dbg_apb_bridge

Interface
REQ-001 Parameter NR_SLAVES, default 4, number of APB slave ports (1..16).
REQ-002 Parameter ADDR_WIDTH, default 5, APB address width.
REQ-003 Parameter DATA_WIDTH, default 32, APB write/read data width (multiple of 8).
REQ-004 Parameter TIMEOUT, default 255, max ACCESS cycles before abort; 0 disables timeout.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  1  debug-port request present.
REQ-008 req_ready  out  1  bridge accepts request this cycle.
REQ-009 req_slave  in  SEL_W  target slave index, SEL_W = max(1,clog2(NR_SLAVES)).
REQ-010 req_wr_rd  in  1  1 = write, 0 = read.
REQ-011 req_addr  in  ADDR_WIDTH  target address.
REQ-012 req_wdata  in  DATA_WIDTH  write data.
REQ-013 req_wstrobe  in  DATA_WIDTH/8  write byte enables.
REQ-014 rsp_valid  out  1  response available.
REQ-015 rsp_ready  in  1  requester consumes response.
REQ-016 rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors).
REQ-017 rsp_err  out  1  slave error, timeout or bad index.
REQ-018 paddr / pwrite / pwdata / pstrb  out  ADDR_WIDTH / 1 / DATA_WIDTH / DATA_WIDTH/8  shared APB request bus.
REQ-019 psel  out  NR_SLAVES  one-hot slave select; penable  out  1  access phase.
REQ-020 pready / pslverr  in  NR_SLAVES each; prdata  in  NR_SLAVES*DATA_WIDTH, slave i at bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-021 FSM states IDLE, SETUP, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-022 IDLE, req_valid=1, req_slave<NR_SLAVES: latch request into paddr/pwrite/pwdata/pstrb and slave index, go SETUP.
REQ-023 IDLE, req_valid=1, req_slave>=NR_SLAVES: no APB cycle, rsp_err=1, rsp_rdata=0, go RESP.
REQ-024 SETUP: psel[idx]=1, penable=0, exactly one cycle, then ACCESS.
REQ-025 ACCESS: psel[idx]=1, penable=1; paddr/pwrite/pwdata/pstrb stable from SETUP through ACCESS end.
REQ-026 ACCESS with pready[idx]=1: capture prdata[idx] (reads only, else 0) and pslverr[idx] into rsp_rdata/rsp_err, deassert psel/penable next cycle, go RESP.
REQ-027 Wait counter clears on SETUP entry, increments each ACCESS cycle with pready[idx]=0; when it reaches TIMEOUT (TIMEOUT>0) go RESP with rsp_err=1, rsp_rdata=0, psel/penable deasserted.
REQ-028 pready arriving in the same cycle the counter hits TIMEOUT SHALL complete normally (pready wins).
REQ-029 pready/pslverr/prdata of unselected slaves SHALL be ignored.
REQ-030 pstrb SHALL be driven 0 for reads.
REQ-031 RESP: rsp_valid=1, rsp_rdata/rsp_err held until rsp_valid&&rsp_ready, then IDLE; no new request accepted in the same cycle.
REQ-032 Latency: request accepted cycle N, zero-wait slave gives rsp_valid at N+3; each slave wait cycle adds one.
REQ-033 psel SHALL be at most one-hot at all times; penable=1 only when psel≠0.

Reset
REQ-034 On rst_n=0, immediately: state IDLE, psel=0, penable=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, paddr/pwdata/pstrb/pwrite=0, counter=0.
REQ-035 Reset mid-transaction SHALL abort it without response; first accept possible the first edge after rst_n rises.

Structure
REQ-036 Package dbg_apb_pkg SHALL hold the FSM state enum and SEL_W width helper function.
REQ-037 The wait counter SHALL be sub-module dbg_apb_timeout (clear, count-enable, expired output, parameter TIMEOUT).

Verification
REQ-038 NR_SLAVES=4: write slave 2 addr 0x0A data 0xDEADBEEF, pready=1 immediately -> psel=4'b0100 for 2 cycles, penable in second, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
REQ-039 Read slave 1, pready after 3 wait cycles, prdata[1]=0x12345678 -> rsp_rdata=0x12345678 at N+6, pstrb=0.
REQ-040 Read slave 3, pready=1 with pslverr[3]=1 -> rsp_err=1; pslverr[0]=1 on unselected slave in other read -> rsp_err=0.
REQ-041 TIMEOUT=8, slave 0 never ready -> abort after 8 ACCESS cycles, rsp_err=1, rsp_rdata=0, psel returns 0.
REQ-042 NR_SLAVES=3, req_slave=3 -> psel never asserted, rsp_valid at N+1 with rsp_err=1.
REQ-043 rst_n low during ACCESS, rsp_ready held 0 in RESP for 5 cycles -> immediate psel=0/rsp_valid=0 on reset; response held stable across stall.
